// File: rtl/top_k_drain.sv
// ---------------------------------------------------------------------------
// top_k_drain
//
// Streaming top-K collector with an ordered read-out port.
//
// In COLLECT the block accepts one unsigned sample per cycle and keeps the K
// largest values seen (duplicates kept) in a register array sorted in
// descending order. A drain request moves it to DRAIN. In DRAIN it presents
// the held values largest-first over a valid/ready port. After the last
// entry is taken it returns to COLLECT with the array empty.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears all state
//   din_valid   din carries a sample this cycle
//   din         unsigned sample, DATA_SIZE bits
//   din_ready   high in COLLECT; a sample is taken on din_valid && din_ready
//   drain       read-out request; only looked at in COLLECT
//   dout_valid  dout holds a valid entry (DRAIN state)
//   dout_ready  consumer accepts dout this cycle
//   dout        current largest remaining entry
//   dout_last   qualifies dout_valid; this is the final entry of the drain
//   count       number of valid entries held, 0..K
// ---------------------------------------------------------------------------
module top_k_drain #(
  parameter int DATA_SIZE = 32,
  parameter int K         = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   din_valid,
  input  logic [DATA_SIZE-1:0]   din,
  output logic                   din_ready,
  input  logic                   drain,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [DATA_SIZE-1:0]   dout,
  output logic                   dout_last,
  output logic [$clog2(K+1)-1:0] count
);

  localparam int CW = $clog2(K+1);

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] entry     [K];
  logic [DATA_SIZE-1:0] ins_entry [K];
  logic [CW-1:0]        ins_pos;
  logic                 ins_take;
  logic [CW-1:0]        count_n;

  // Insert position: the lowest valid slot holding a strictly smaller value.
  // Equal values therefore land after their existing twins. If no slot
  // qualifies, the position is count, which is K when the array is full.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ins_pos = count;
    for (int i = K - 1; i >= 0; i--) begin
      if ((CW'(i) < count) && (din > entry[i])) ins_pos = CW'(i);
    end
  end

  // Array as it would look after inserting din at ins_pos. Slots at and
  // after the insert position shift down by one, and the old last slot
  // drops off. Slots past count are always zero, so shifting them in is
  // harmless.
  always_comb begin
    ins_entry[0] = (ins_pos == '0) ? din : entry[0];
    for (int i = 1; i < K; i++) begin
      if (CW'(i) < ins_pos)       ins_entry[i] = entry[i];
      else if (CW'(i) == ins_pos) ins_entry[i] = din;
      else                        ins_entry[i] = entry[i-1];
    end
  end

  // A sample is only stored when it finds a slot. count grows until it
  // reaches K, then stays there.
  assign ins_take = din_valid && (ins_pos != CW'(K));
  assign count_n  = (ins_take && (count != CW'(K))) ? count + 1'b1 : count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // entry shift reads the values from before the edge.
  // NOTE: the entry array is a small register file, not a RAM. It is reset,
  // so a drain that is aborted by reset leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
      count <= '0;
      for (int i = 0; i < K; i++) entry[i] <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (ins_take) begin
            for (int i = 0; i < K; i++) entry[i] <= ins_entry[i];
            count <= count_n;
          end
          // A same-cycle sample is already counted in count_n, so it
          // becomes part of the drain.
          if (drain && (count_n != '0)) state <= DRAIN;
        end
        DRAIN: begin
          if (dout_ready) begin
            for (int i = 0; i < K - 1; i++) entry[i] <= entry[i+1];
            entry[K-1] <= '0;
            count      <= count - 1'b1;
            if (count == CW'(1)) state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // These outputs decode the state register directly, so reset drops
  // dout_valid at once without waiting for a clock edge.
  assign din_ready  = (state == COLLECT);
  assign dout_valid = (state == DRAIN);
  assign dout       = entry[0];
  assign dout_last  = (state == DRAIN) && (count == CW'(1));

endmodule
